// File: rtl/border_mask.sv
// Masks pixels on the image border with BORDER_VAL and checks frame geometry.
// Two register stages: the second one lets eol_o see whether the next beat continues the line.
module border_mask #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int CNT_W = 12,
  parameter logic [DATA_WIDTH-1:0] BORDER_VAL = '0
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  input  logic                  frame_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  frame_o,
  output logic                  sol_o,
  output logic                  eol_o,
  output logic                  err_o
);

  typedef enum logic [1:0] {SYNC, IDLE, ACTIVE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IMG_H - 1);
  localparam logic [CNT_W-1:0] W_LEN    = CNT_W'(IMG_W);
  localparam logic [CNT_W:0]   H_LEN    = (CNT_W + 1)'(IMG_H);

  state_t state, state_nxt;
  logic [CNT_W-1:0] col, row;
  logic [CNT_W:0] lines_done;
  logic in_line, accept, frame_end, clr_err, line_end, border, len_err, cnt_err;
  logic [DATA_WIDTH-1:0] s1_data;
  logic s1_valid, s1_sol, s1_frame;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    frame_end = 1'b0;
    clr_err   = 1'b0;
    case (state)
      SYNC: begin
        if (!frame_i) state_nxt = IDLE;
      end
      IDLE: begin
        if (frame_i) begin
          state_nxt = ACTIVE;
          clr_err   = 1'b1;
          accept    = valid_i;
        end
      end
      ACTIVE: begin
        if (!frame_i) begin
          state_nxt = IDLE;
          frame_end = 1'b1;
        end else begin
          accept = valid_i;
        end
      end
      default: state_nxt = SYNC;
    endcase
  end

  // Any cycle without an accepted beat terminates the current line.
  assign line_end   = in_line & ~accept;
  assign border     = (col == '0) | (col >= COL_LAST) | (row == '0) | (row >= ROW_LAST);
  assign lines_done = {1'b0, row} + {{CNT_W{1'b0}}, in_line};
  assign len_err    = line_end & (col != W_LEN);
  assign cnt_err    = frame_end & (lines_done != H_LEN);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state    <= SYNC;
      in_line  <= 1'b0;
      col      <= '0;
      row      <= '0;
      err_o    <= 1'b0;
      s1_data  <= '0;
      s1_valid <= 1'b0;
      s1_sol   <= 1'b0;
      s1_frame <= 1'b0;
      data_o   <= '0;
      valid_o  <= 1'b0;
      sol_o    <= 1'b0;
      eol_o    <= 1'b0;
      frame_o  <= 1'b0;
    end else begin
      state   <= state_nxt;
      in_line <= accept;

      if (!accept)
        col <= '0;
      else if (col != CNT_MAX)
        col <= col + 1'b1;

      if (state != ACTIVE || !frame_i)
        row <= '0;
      else if (line_end && row != CNT_MAX)
        row <= row + 1'b1;

      if (len_err || cnt_err)
        err_o <= 1'b1;
      else if (clr_err)
        err_o <= 1'b0;

      s1_valid <= accept;
      s1_data  <= accept ? (border ? BORDER_VAL : data_i) : '0;
      s1_sol   <= accept & ~in_line;
      s1_frame <= frame_i;

      data_o  <= s1_data;
      valid_o <= s1_valid;
      sol_o   <= s1_sol;
      eol_o   <= s1_valid & ~accept;
      frame_o <= s1_frame;
    end
  end

endmodule

// File: tb/tb_border_mask.sv
// Directed bench for border_mask: a 4x3 instance for geometry/masking and a 1x3 instance for single-beat lines.
module tb_border_mask;
  logic clk_i = 1'b0, reset_i = 1'b1, valid_i = 1'b0, frame_i = 1'b0;
  logic [7:0] data_i = 8'd0;
  logic [7:0] data_o, data1;
  logic valid_o, frame_o, sol_o, eol_o, err_o;
  logic valid1, frame1, sol1, eol1, err1;
  int nchecks = 0, nerrors = 0, cyc = 0;

  typedef struct { logic [7:0] d; logic s; logic e; int c; } beat_t;
  beat_t q[$];
  int fo_q[$];
  logic fo_prev = 1'b0;

  border_mask #(.DATA_WIDTH(8), .IMG_W(4), .IMG_H(3), .CNT_W(12), .BORDER_VAL(8'h00)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .data_i(data_i), .valid_i(valid_i), .frame_i(frame_i),
    .data_o(data_o), .valid_o(valid_o), .frame_o(frame_o), .sol_o(sol_o), .eol_o(eol_o), .err_o(err_o));

  border_mask #(.DATA_WIDTH(8), .IMG_W(1), .IMG_H(3), .CNT_W(12), .BORDER_VAL(8'h5A)) dut1 (
    .clk_i(clk_i), .reset_i(reset_i), .data_i(data_i), .valid_i(valid_i), .frame_i(frame_i),
    .data_o(data1), .valid_o(valid1), .frame_o(frame1), .sol_o(sol1), .eol_o(eol1), .err_o(err1));

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (valid_o) q.push_back('{data_o, sol_o, eol_o, cyc});
    if (frame_o && !fo_prev) fo_q.push_back(cyc);
    fo_prev <= frame_o;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit expired, required reaching the summary");
    $fatal(1);
  end

  task automatic drive(input logic v, input logic f, input logic [7:0] d);
    valid_i = v; frame_i = f; data_i = d;
    @(posedge clk_i); #1;
  endtask

  task automatic frame_start(output int c);
    c = cyc;
    drive(1'b0, 1'b1, 8'd0);
  endtask

  task automatic send_line(input int n, input int start);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 8'(start + i));
    drive(1'b0, 1'b1, 8'd0);
    drive(1'b0, 1'b1, 8'd0);
  endtask

  task automatic frame_stop();
    repeat (3) drive(1'b0, 1'b0, 8'd0);
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    nchecks++;
    if ({data_o, valid_o, frame_o, sol_o, eol_o, err_o} !== 13'd0) begin
      nerrors++;
      $display("FAIL reset_outputs: got %h, required 0", {data_o, valid_o, frame_o, sol_o, eol_o, err_o});
    end
    reset_i = 1'b0;
    drive(1'b0, 1'b0, 8'd0);
    drive(1'b0, 1'b0, 8'd0);
    nchecks++;
    if (valid_o !== 1'b0 || err_o !== 1'b0) begin
      nerrors++;
      $display("FAIL post_reset_idle: valid_o=%b err_o=%b, required 0 0", valid_o, err_o);
    end
  endtask

  task automatic test_basic();
    logic [7:0] exp_d [12];
    int fr, inb, qb, fb;
    exp_d = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd6, 8'd7, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    qb = q.size(); fb = fo_q.size();
    frame_start(fr);
    inb = cyc;
    send_line(4, 1); send_line(4, 5); send_line(4, 9);
    frame_stop();
    nchecks++;
    if (q.size() - qb != 12) begin
      nerrors++;
      $display("FAIL basic_beats: got %0d beats, required 12", q.size() - qb);
    end
    for (int i = 0; i < 12 && qb + i < q.size(); i++) begin
      nchecks++;
      if (q[qb+i].d !== exp_d[i] || q[qb+i].s !== (i % 4 == 0) || q[qb+i].e !== (i % 4 == 3)) begin
        nerrors++;
        $display("FAIL basic_beat%0d: data=%0d sol=%b eol=%b, required data=%0d sol=%b eol=%b",
                 i, q[qb+i].d, q[qb+i].s, q[qb+i].e, exp_d[i], (i % 4 == 0), (i % 4 == 3));
      end
    end
    if (q.size() > qb) begin
      nchecks++;
      if (q[qb].c - inb != 2) begin
        nerrors++;
        $display("FAIL basic_latency: got %0d cycles, required 2", q[qb].c - inb);
      end
    end
    nchecks++;
    if (fo_q.size() <= fb) begin
      nerrors++;
      $display("FAIL frame_latency: frame_o never rose, required rise after 2 cycles");
    end else if (fo_q[fb] - fr != 2) begin
      nerrors++;
      $display("FAIL frame_latency: got %0d cycles, required 2", fo_q[fb] - fr);
    end
    nchecks++;
    if (err_o !== 1'b0) begin
      nerrors++;
      $display("FAIL basic_err: got %b, required 0", err_o);
    end
  endtask

  task automatic test_short_line();
    logic [7:0] exp_d [11];
    int fr, qb;
    exp_d = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd6, 8'd7, 8'd0, 8'd0, 8'd0, 8'd0};
    qb = q.size();
    frame_start(fr);
    send_line(4, 1);
    drive(1'b1, 1'b1, 8'd5); drive(1'b1, 1'b1, 8'd6); drive(1'b1, 1'b1, 8'd7);
    nchecks++;
    if (err_o !== 1'b0) begin
      nerrors++;
      $display("FAIL short_err_before_end: got %b, required 0", err_o);
    end
    drive(1'b0, 1'b1, 8'd0);
    nchecks++;
    if (err_o !== 1'b1) begin
      nerrors++;
      $display("FAIL short_err_at_end: got %b, required 1", err_o);
    end
    drive(1'b0, 1'b1, 8'd0);
    send_line(4, 8);
    frame_stop();
    nchecks++;
    if (err_o !== 1'b1) begin
      nerrors++;
      $display("FAIL short_err_sticky: got %b, required 1", err_o);
    end
    nchecks++;
    if (q.size() - qb != 11) begin
      nerrors++;
      $display("FAIL short_beats: got %0d beats, required 11", q.size() - qb);
    end
    for (int i = 0; i < 11 && qb + i < q.size(); i++) begin
      nchecks++;
      if (q[qb+i].d !== exp_d[i] || q[qb+i].e !== (i == 3 || i == 6 || i == 10)) begin
        nerrors++;
        $display("FAIL short_beat%0d: data=%0d eol=%b, required data=%0d eol=%b",
                 i, q[qb+i].d, q[qb+i].e, exp_d[i], (i == 3 || i == 6 || i == 10));
      end
    end
    frame_start(fr);
    nchecks++;
    if (err_o !== 1'b0) begin
      nerrors++;
      $display("FAIL err_clear_on_rise: got %b, required 0", err_o);
    end
    send_line(4, 1); send_line(4, 5); send_line(4, 9);
    frame_stop();
    nchecks++;
    if (err_o !== 1'b0) begin
      nerrors++;
      $display("FAIL good_frame_err: got %b, required 0", err_o);
    end
  endtask

  task automatic test_extra_lines();
    logic [7:0] exp_d [16];
    int fr, qb;
    exp_d = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd6, 8'd7, 8'd0,
              8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    qb = q.size();
    frame_start(fr);
    send_line(4, 1); send_line(4, 5); send_line(4, 9); send_line(4, 13);
    nchecks++;
    if (err_o !== 1'b0) begin
      nerrors++;
      $display("FAIL extra_err_before_fall: got %b, required 0", err_o);
    end
    drive(1'b0, 1'b0, 8'd0);
    nchecks++;
    if (err_o !== 1'b1) begin
      nerrors++;
      $display("FAIL extra_err_after_fall: got %b, required 1", err_o);
    end
    drive(1'b0, 1'b0, 8'd0); drive(1'b0, 1'b0, 8'd0);
    nchecks++;
    if (q.size() - qb != 16) begin
      nerrors++;
      $display("FAIL extra_beats: got %0d beats, required 16", q.size() - qb);
    end
    for (int i = 0; i < 16 && qb + i < q.size(); i++) begin
      nchecks++;
      if (q[qb+i].d !== exp_d[i]) begin
        nerrors++;
        $display("FAIL extra_beat%0d: data=%0d, required %0d", i, q[qb+i].d, exp_d[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp_d [12];
    int fr, qb;
    exp_d = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd6, 8'd7, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    frame_start(fr);
    send_line(3, 1);
    nchecks++;
    if (err_o !== 1'b1) begin
      nerrors++;
      $display("FAIL rst_err_before: got %b, required 1", err_o);
    end
    drive(1'b1, 1'b1, 8'd5); drive(1'b1, 1'b1, 8'd6);
    reset_i = 1'b1; valid_i = 1'b1; frame_i = 1'b1; data_i = 8'd7;
    @(posedge clk_i); #1;
    nchecks++;
    if (data_o !== 8'd0) begin
      nerrors++;
      $display("FAIL rst_mid_data: got %0d, required 0", data_o);
    end
    nchecks++;
    if ({valid_o, frame_o, sol_o, eol_o, err_o} !== 5'd0) begin
      nerrors++;
      $display("FAIL rst_mid_flags: got %b, required 00000", {valid_o, frame_o, sol_o, eol_o, err_o});
    end
    reset_i = 1'b0;
    qb = q.size();
    drive(1'b1, 1'b1, 8'd8);
    drive(1'b0, 1'b1, 8'd0); drive(1'b0, 1'b1, 8'd0);
    send_line(4, 9);
    frame_stop();
    nchecks++;
    if (q.size() != qb) begin
      nerrors++;
      $display("FAIL rst_discard: got %0d valid beats, required 0", q.size() - qb);
    end
    qb = q.size();
    frame_start(fr);
    send_line(4, 1); send_line(4, 5); send_line(4, 9);
    frame_stop();
    nchecks++;
    if (q.size() - qb != 12) begin
      nerrors++;
      $display("FAIL rst_next_beats: got %0d beats, required 12", q.size() - qb);
    end
    for (int i = 0; i < 12 && qb + i < q.size(); i++) begin
      nchecks++;
      if (q[qb+i].d !== exp_d[i]) begin
        nerrors++;
        $display("FAIL rst_next_beat%0d: data=%0d, required %0d", i, q[qb+i].d, exp_d[i]);
      end
    end
    nchecks++;
    if (err_o !== 1'b0) begin
      nerrors++;
      $display("FAIL rst_next_err: got %b, required 0", err_o);
    end
  endtask

  task automatic test_frame_low();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 8'(8'hC0 + i));
      nchecks++;
      if (valid_o !== 1'b0 || data_o !== 8'd0) begin
        nerrors++;
        $display("FAIL frame_low%0d: valid_o=%b data_o=%0d, required 0 0", i, valid_o, data_o);
      end
    end
    drive(1'b0, 1'b0, 8'd0);
  endtask

  task automatic test_single_beat();
    int fr;
    frame_start(fr);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 8'(21 + k));
      drive(1'b0, 1'b1, 8'd0);
      nchecks++;
      if (valid1 !== 1'b1 || sol1 !== 1'b1 || eol1 !== 1'b1 || data1 !== 8'h5A) begin
        nerrors++;
        $display("FAIL single_beat%0d: valid=%b sol=%b eol=%b data=%h, required 1 1 1 5a",
                 k, valid1, sol1, eol1, data1);
      end
      drive(1'b0, 1'b1, 8'd0);
      nchecks++;
      if (valid1 !== 1'b0) begin
        nerrors++;
        $display("FAIL single_gap%0d: valid=%b, required 0", k, valid1);
      end
    end
    frame_stop();
    nchecks++;
    if (err1 !== 1'b0) begin
      nerrors++;
      $display("FAIL single_err: got %b, required 0", err1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short_line();
    test_extra_lines();
    test_reset_mid();
    test_frame_low();
    test_single_beat();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
